sgd_data_loader: RTL and testbench

SGD_DATA_LOADER -- requirements
Module: sgd_data_loader

---
 rtl/sgd_data_loader.sv | 139 +++++++++++++
 tb/tb_sgd_data_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_data_loader.sv
// sgd_data_loader: assembles streamed label/feature words into packed rows,
// stores them in a small row memory and signals the trainer when loading is complete.
module sgd_data_loader #(
    parameter int LENGTH     = 16,
    parameter int F          = 11,
    parameter int DP         = 4,
    parameter int DATA_WIDTH = (F + 1) * LENGTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  go,
    input  logic [3:0]            feat,
    input  logic [11:0]           data_points,
    input  logic [LENGTH-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [11:0]           rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  load_done,
    output logic                  start,
    output logic                  cfg_err
);

    localparam int AW = (DP > 1) ? $clog2(DP) : 1;

    localparam logic [3:0]  FMAX  = 4'(F);
    localparam logic [11:0] DPMAX = 12'(DP);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            r_state;
    logic [3:0]            r_feat;
    logic [11:0]           r_dp;
    logic [3:0]            r_wcnt;
    logic [11:0]           r_dpcnt;
    logic [DATA_WIDTH-1:0] r_row;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_start;
    logic                  r_cfg_err;

    logic [DATA_WIDTH-1:0] r_mem [DP];

    logic w_cfg_ok;
    logic w_xfer;
    logic w_rd_ok;
    logic w_last_dp;

    assign w_cfg_ok  = (feat != 4'd0) && (feat <= FMAX) &&
                       (data_points != 12'd0) && (data_points <= DPMAX);
    assign w_xfer    = (r_state == S_LOAD) && in_valid;
    assign w_rd_ok   = (rd_addr < DPMAX);
    assign w_last_dp = (r_dpcnt == (r_dp - 12'd1));

    assign in_ready  = (r_state == S_LOAD);
    assign load_done = (r_state == S_DONE);
    assign start     = r_start;
    assign cfg_err   = r_cfg_err;
    assign rd_data   = r_rd_data;

    // Control FSM: configuration capture, word assembly and row commit sequencing
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_feat    <= 4'd0;
            r_dp      <= 12'd0;
            r_wcnt    <= 4'd0;
            r_dpcnt   <= 12'd0;
            r_row     <= '0;
            r_start   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (go) begin
                        if (w_cfg_ok) begin
                            r_feat    <= feat;
                            r_dp      <= data_points;
                            r_wcnt    <= 4'd0;
                            r_dpcnt   <= 12'd0;
                            r_row     <= '0;
                            r_cfg_err <= 1'b0;
                            r_state   <= S_LOAD;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        for (int k = 0; k <= F; k++) begin
                            if (r_wcnt == 4'(k)) begin
                                r_row[DATA_WIDTH-1-LENGTH*k -: LENGTH] <= in_data;
                            end
                        end
                        r_wcnt <= r_wcnt + 4'd1;
                        if (r_wcnt == r_feat) begin
                            r_state <= S_COMMIT;
                        end
                    end
                end
                S_COMMIT: begin
                    r_row  <= '0;
                    r_wcnt <= 4'd0;
                    if (w_last_dp) begin
                        r_state <= S_DONE;
                        r_start <= 1'b1;
                    end else begin
                        r_dpcnt <= r_dpcnt + 12'd1;
                        r_state <= S_LOAD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Row memory write; contents survive reset, but reset blocks a commit in flight
    always_ff @(posedge CLK) begin
        if (!RST && (r_state == S_COMMIT)) begin
            r_mem[r_dpcnt[AW-1:0]] <= r_row;
        end
    end

    // Registered read port; same-cycle commit to the read address returns old data
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data <= '0;
        end else if (w_rd_ok) begin
            r_rd_data <= r_mem[rd_addr[AW-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_sgd_data_loader.sv
// tb_sgd_data_loader: randomized self-checking bench for sgd_data_loader,
// compared against a word-array model of the stored rows.
module tb_sgd_data_loader;

    localparam int LENGTH = 16;
    localparam int F      = 11;
    localparam int DP     = 4;
    localparam int DW     = (F + 1) * LENGTH;

    logic            CLK;
    logic            RST;
    logic            go;
    logic [3:0]      feat;
    logic [11:0]     data_points;
    logic [15:0]     in_data;
    logic            in_valid;
    logic            in_ready;
    logic [11:0]     rd_addr;
    logic [DW-1:0]   rd_data;
    logic            load_done;
    logic            start;
    logic            cfg_err;

    int total;
    int bad;

    logic [15:0] wds [DP][F+1];
    logic [15:0] mdl [DP][F+1];
    bit          known [DP];

    sgd_data_loader dut (
        .CLK         (CLK),
        .RST         (RST),
        .go          (go),
        .feat        (feat),
        .data_points (data_points),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .load_done   (load_done),
        .start       (start),
        .cfg_err     (cfg_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] pack(input int r);
        logic [DW-1:0] p;
        p = '0;
        for (int k = 0; k <= F; k++) begin
            p = (p << LENGTH) | DW'(mdl[r][k]);
        end
        return p;
    endfunction

    task automatic rd_chk(input int a);
        rd_addr = 12'(a);
        tick();
        if (a >= DP) begin
            chk("rd_oob", rd_data, '0);
        end else if (known[a]) begin
            chk("rd_row", rd_data, pack(a));
        end
    endtask

    task automatic rand_words(input int n, input int f);
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k <= F; k++) begin
                wds[r][k] = (k <= f) ? 16'($urandom) : 16'h0;
            end
        end
    endtask

    // mode 0: valid always, 1: valid 1,0,0 repeating, 2: random valid and stray go
    task automatic do_load(input int f, input int n, input int mode);
        int c;
        int guard;
        bit v;
        logic [DW-1:0] old;
        bit old_known;
        go          = 1'b1;
        feat        = 4'(f);
        data_points = 12'(n);
        tick();
        go = 1'b0;
        chk("go_cfg_err", DW'(cfg_err), '0);
        chk("go_ready", DW'(in_ready), DW'(1));
        chk("go_done", DW'(load_done), '0);
        c = 0;
        for (int r = 0; r < n; r++) begin
            for (int k = 0; k <= f; k++) begin
                guard = 0;
                do begin
                    case (mode)
                        0: v = 1'b1;
                        1: v = (c % 3 == 0);
                        default: v = 1'($urandom);
                    endcase
                    c++;
                    guard++;
                    in_valid = v;
                    in_data  = v ? wds[r][k] : 16'($urandom);
                    if (mode == 2) begin
                        go   = 1'($urandom);
                        feat = 4'd0;
                    end
                    chk("ld_ready", DW'(in_ready), DW'(1));
                    tick();
                end while (!v && guard < 100);
                if (!v) chk("ld_guard", DW'(0), DW'(1));
            end
            go        = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'($urandom);
            rd_addr   = 12'(r);
            old_known = known[r];
            old       = pack(r);
            chk("cm_ready", DW'(in_ready), '0);
            chk("cm_start", DW'(start), '0);
            tick();
            if (old_known) chk("cm_rd_old", rd_data, old);
            for (int k = 0; k <= F; k++) mdl[r][k] = (k <= f) ? wds[r][k] : 16'h0;
            known[r] = 1'b1;
            if (r == n - 1) begin
                chk("end_start", DW'(start), DW'(1));
                chk("end_done", DW'(load_done), DW'(1));
            end else begin
                chk("nx_ready", DW'(in_ready), DW'(1));
                chk("nx_done", DW'(load_done), '0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("pulse_end", DW'(start), '0);
        chk("hold_done", DW'(load_done), DW'(1));
        chk("done_ready", DW'(in_ready), '0);
        chk("done_cfg", DW'(cfg_err), '0);
    endtask

    task automatic bad_go(input int f, input int n);
        go          = 1'b1;
        feat        = 4'(f);
        data_points = 12'(n);
        tick();
        go = 1'b0;
        chk("bad_cfg_err", DW'(cfg_err), DW'(1));
        chk("bad_ready", DW'(in_ready), '0);
        tick();
        chk("bad_idle", DW'(in_ready), '0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        RST         = 1'b1;
        go          = 1'b0;
        feat        = 4'd0;
        data_points = 12'd0;
        in_data     = 16'h0;
        in_valid    = 1'b0;
        rd_addr     = 12'd0;
        for (int r = 0; r < DP; r++) known[r] = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_ready", DW'(in_ready), '0);
        chk("rst_done", DW'(load_done), '0);
        chk("rst_start", DW'(start), '0);
        chk("rst_cfg", DW'(cfg_err), '0);
        chk("rst_rd", rd_data, '0);

        wds[0][0] = 16'h0F00; wds[0][1] = 16'h0200; wds[0][2] = 16'h0400;
        wds[0][3] = 16'h0300; wds[0][4] = 16'h0600;
        wds[1][0] = 16'h1200; wds[1][1] = 16'h0300; wds[1][2] = 16'h0400;
        wds[1][3] = 16'h0500; wds[1][4] = 16'h0600;
        do_load(4, 2, 0);
        rd_addr = 12'd1;
        tick();
        chk("basic_row1", rd_data,
            {16'h1200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 112'h0});
        rd_chk(0);
        rd_chk(5);

        bad_go(0, 2);
        bad_go(12, 2);
        bad_go(3, 5);
        bad_go(3, 0);

        rand_words(4, 11);
        do_load(11, 4, 2);
        for (int a = 0; a < DP; a++) rd_chk(a);
        rd_chk(7);

        rand_words(3, 3);
        do_load(3, 3, 1);
        for (int a = 0; a < DP; a++) rd_chk(a);

        chk("pre_reload", DW'(load_done), DW'(1));
        rand_words(2, 2);
        do_load(2, 2, 0);
        for (int a = 0; a < DP; a++) rd_chk(a);

        go          = 1'b1;
        feat        = 4'd5;
        data_points = 12'd2;
        tick();
        go       = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 16'($urandom);
            tick();
        end
        RST     = 1'b1;
        go      = 1'b1;
        rd_addr = 12'd0;
        tick();
        RST      = 1'b0;
        go       = 1'b0;
        in_valid = 1'b0;
        chk("mid_ready", DW'(in_ready), '0);
        chk("mid_done", DW'(load_done), '0);
        chk("mid_start", DW'(start), '0);
        chk("mid_rd", rd_data, '0);
        tick();
        chk("mid_idle", DW'(in_ready), '0);
        rd_chk(0);
        rd_chk(3);

        for (int it = 0; it < 4; it++) begin
            int f;
            int n;
            f = $urandom_range(1, F);
            n = $urandom_range(1, DP);
            rand_words(n, f);
            do_load(f, n, 2);
            for (int a = 0; a < DP; a++) rd_chk(a);
            rd_chk($urandom_range(DP, 4095));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
